// File: rtl/pe_gather_fifo.sv
// Width-converting ring FIFO: pushes WR_N elements per row and presents up to
// RD_N oldest elements first-word-fall-through, retiring 0..RD_N per cycle.
module pe_gather_fifo #(
   parameter int WIDTH = 8,
   parameter int WR_N  = 4,
   parameter int RD_N  = 2,
   parameter int DEPTH = 4,
   localparam int CAP  = WR_N * DEPTH,
   localparam int PW   = $clog2(CAP),
   localparam int CW   = $clog2(CAP) + 1,
   localparam int NW   = $clog2(RD_N + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       psh,
   input  logic [WR_N-1:0][WIDTH-1:0] din,
   output logic                       psh_rdy,
   input  logic [NW-1:0]              pop,
   output logic [RD_N-1:0][WIDTH-1:0] dout,
   output logic [NW-1:0]              avail,
   output logic [CW-1:0]              cnt,
   output logic                       ovf,
   output logic                       udf
);

   // Producer side: a row is accepted when psh && psh_rdy; psh while !psh_rdy
   // is dropped and flagged. Consumer side: dout[0..avail-1] are valid, and
   // pop elements are retired when pop <= avail; larger pops are ignored.

   logic [WIDTH-1:0] ring_q [CAP];
   logic [WIDTH-1:0] ring_d [CAP];
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             psh_ok, pop_bad, pop_ok;

   // Operands never exceed 2*CAP-1, so one conditional subtract is a full modulo.
   function automatic logic [PW-1:0] wrap(input int s);
      return (s >= CAP) ? PW'(s - CAP) : PW'(s);
   endfunction

   assign psh_rdy = (cnt_q <= CW'(CAP - WR_N));
   assign avail   = (cnt_q >= CW'(RD_N)) ? NW'(RD_N) : NW'(cnt_q);
   assign cnt     = cnt_q;
   assign ovf     = ovf_q;
   assign udf     = udf_q;

   assign psh_ok  = psh && psh_rdy;
   assign pop_bad = (pop > avail);
   assign pop_ok  = !pop_bad && (pop != '0);

   always_comb begin
      for (int j = 0; j < RD_N; j++) begin
         dout[j] = (j < int'(avail)) ? ring_q[wrap(int'(rptr_q) + j)] : '0;
      end
   end

   always_comb begin
      ring_d = ring_q;
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;
      if (flush) begin
         rptr_d = '0;
         wptr_d = '0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
         udf_d  = 1'b0;
      end else begin
         if (psh && !psh_rdy) ovf_d = 1'b1;
         if (pop_bad)         udf_d = 1'b1;
         if (psh_ok) begin
            for (int i = 0; i < WR_N; i++) begin
               ring_d[wrap(int'(wptr_q) + i)] = din[i];
            end
            wptr_d = wrap(int'(wptr_q) + WR_N);
         end
         if (pop_ok) rptr_d = wrap(int'(rptr_q) + int'(pop));
         cnt_d = cnt_q + (psh_ok ? CW'(WR_N) : '0) - (pop_ok ? CW'(pop) : '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CAP; k++) ring_q[k] <= '0;
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         ring_q <= ring_d;
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

endmodule

// File: doc/pe_gather_fifo.md
# pe_gather_fifo

Parametrised width-converting input FIFO for the systolic PE array, feeding weights or activations from the wide load path to a narrower PE-side consumer. The write side accepts WR_N elements per push; the read side presents up to RD_N oldest elements and retires 0..RD_N of them per cycle. It adds backpressure, occupancy reporting, flush and sticky overflow/underflow flags.

## Interface
- WIDTH, 8, bits per element
- WR_N, 4, elements written per push (≥1)
- RD_N, 2, max elements popped per cycle (1 ≤ RD_N ≤ CAP)
- DEPTH, 4, storage rows of WR_N elements (≥2); CAP = WR_N*DEPTH elements
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of pointers, count and error flags
- psh  in  1  push one row of WR_N elements
- din  in  [WR_N][WIDTH]  push data; din[0] is oldest
- psh_rdy  out  1  ≥WR_N free slots (CAP−cnt ≥ WR_N)
- pop  in  $clog2(RD_N+1)  elements to retire this cycle, 0..RD_N
- dout  out  [RD_N][WIDTH]  head elements; dout[0] is oldest
- avail  out  $clog2(RD_N+1)  valid lanes in dout = min(cnt, RD_N)
- cnt  out  $clog2(CAP)+1  stored element count, 0..CAP
- ovf  out  1  sticky: push attempted while !psh_rdy
- udf  out  1  sticky: pop > avail attempted

## Operation
- Storage is a flat ring of CAP elements. Write pointer advances WR_N per push; read pointer advances by pop. Both wrap modulo CAP.
- Push: when psh && psh_rdy, din[i] is written to ring[(wptr+i) mod CAP] for i in 0..WR_N−1. When psh && !psh_rdy, the push is dropped, ovf is set and no state changes.
- Pop: when 0 < pop ≤ avail, rptr += pop (mod CAP). When pop > avail, the pop is ignored entirely and udf is set. Values of pop > RD_N are treated as pop > avail.
- cnt next = cnt + (push accepted ? WR_N : 0) − (pop accepted ? pop : 0). Push and pop are judged independently against current-cycle state.
- dout[j] = ring[(rptr+j) mod CAP] for j < avail, else 0. Reads across the wrap boundary gather correctly. dout is first-word-fall-through and does not depend on pop.
- psh_rdy depends on registered cnt only. Space freed by a same-cycle pop does not raise psh_rdy that cycle.
- Flush has priority over push and pop in the same cycle. On flush, rptr, wptr and cnt go to 0, ovf and udf clear, any same-cycle psh/pop is discarded and no flags are raised. Stored data is not cleared.
- ovf and udf remain set until flush or reset.

## Timing
- All state updates on posedge clk. rst_n low asynchronously clears rptr, wptr, cnt, ovf, udf and ring contents.
- Reset outputs: psh_rdy=1, avail=0, cnt=0, dout=0, ovf=0, udf=0.
- Outputs are combinational from registers only; there is no input-to-output combinational path.
- Push latency: data pushed at edge N is visible on dout, and reflected in avail and cnt, after edge N.
- Pop effect is visible after the same edge. Back-to-back pops of RD_N every cycle are sustained while cnt ≥ RD_N.
- Full throughput: one push per cycle sustained while the consumer drains WR_N elements per cycle on average.
- Reset asserted mid-operation drops all contents; after release the block behaves as post-reset empty.

## Test plan
- Reset check (defaults WIDTH=8, WR_N=4, RD_N=2, DEPTH=4, CAP=16): hold rst_n low → psh_rdy=1, avail=0, cnt=0, dout=0, ovf=udf=0. Then push din={0x03,0x02,0x01,0x00} → next cycle cnt=4, avail=2, dout={0x01,0x00}.
- Mixed pops: fill 8 elements 0x00..0x07, apply pop=1, 2, 2, 1, 2 → dout heads 0x00, 0x01, 0x03, 0x05, 0x06, and cnt goes 7, 5, 3, 2, 0.
- Full and overflow: 4 pushes → cnt=16, psh_rdy=0. A 5th push → ovf=1, cnt stays 16 and contents are unchanged. Pop=2 plus psh in the same cycle → push dropped (psh_rdy was 0), cnt=14.
- Wrap gather: push 4 rows, pop 15 elements one at a time, push 0x40..0x43 → cnt=5, dout={0x40,0x0F}, where the pair spans ring index 15→0.
- Underflow: with cnt=1, pop=2 → udf=1, cnt stays 1, rptr unchanged. A following pop=1 is accepted and cnt=0.
- Flush priority: with cnt=6 and ovf=1, assert flush together with psh and pop=2 → next cycle cnt=0, ovf=udf=0, avail=0, psh_rdy=1. Then assert rst_n low mid-stream → all outputs return to reset values asynchronously.
